// File: rtl/uart_tx_framer.sv
// UART serialiser: start, LSB-first data, optional even parity, 1-2 stop bits. tx_out lags state by one clk.
// Accepts one byte per frame (tx_ready only in IDLE); tx_valid while busy is ignored, never queued.
module uart_tx_framer #(
   parameter int DATA_BITS = 8,
   parameter int PARITY_EN = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   output logic                 div_en,
   output logic                 div_clear,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 busy
);

   localparam int CW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [CW-1:0]        cnt_q;
   logic                 par_q;
   logic                 stop_q;
   logic                 tx_out_q;
   logic                 accept;

   assign tx_ready  = (state_q == S_IDLE);
   assign busy      = ~tx_ready;
   assign div_en    = (state_q != S_IDLE);
   assign accept    = tx_valid && tx_ready;
   // Restarting the divider on accept keeps the start bit a full period even if a tick lands now.
   assign div_clear = accept;
   assign tx_out    = tx_out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         par_q    <= 1'b0;
         stop_q   <= 1'b0;
         tx_out_q <= 1'b1;
      end else begin
         // Line level reflects the state held during the previous cycle.
         case (state_q)
            S_START:  tx_out_q <= 1'b0;
            S_DATA:   tx_out_q <= shift_q[0];
            S_PARITY: tx_out_q <= par_q;
            default:  tx_out_q <= 1'b1;
         endcase

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  shift_q <= tx_data;
                  par_q   <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  cnt_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  shift_q <= shift_q >> 1;
                  par_q   <= par_q ^ shift_q[0];
                  stop_q  <= 1'b0;
                  if (cnt_q == LAST_BIT) begin
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  stop_q  <= 1'b0;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (baud_tick) begin
                  if ((STOP_BITS == 1) || stop_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     stop_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
